// File: rtl/pc_fetch_unit.sv
// Program counter for a multi-cycle fetch: one instruction slot every CYCLES_PER_INSTR edges, PC updated on the commit edge.
// readAddress is registered and changes only on a commit edge or reset; there is no backpressure, since a stall holds the PC for one slot.
module pc_fetch_unit #(
    parameter int CYCLES_PER_INSTR = 10,
    parameter int MEM_WORDS        = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    input  logic        halt_req,
    output logic [31:0] readAddress,
    output logic [31:0] pc_plus_one,
    output logic [3:0]  phase,
    output logic        decode_strobe,
    output logic        commit_strobe,
    output logic [15:0] retired,
    output logic        halted,
    output logic        addr_fault
);

    localparam logic [3:0]  LAST_PHASE = 4'(CYCLES_PER_INSTR - 1);
    localparam logic [31:0] MEM_LIMIT  = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        STOPPED = 2'd1,
        FAULTED = 2'd2
    } run_state_t;

    run_state_t  state;
    run_state_t  state_next;
    logic        commit_edge;
    logic        slot_commit;
    logic        pc_load;
    logic        pc_fault;
    logic [31:0] next_pc;

    assign commit_edge = (phase == LAST_PHASE);
    assign halted      = (state != RUNNING);
    assign addr_fault  = (state == FAULTED);
    assign slot_commit = commit_edge && !halted;
    assign pc_plus_one = readAddress + 32'd1;

    // Reset is synchronous, so the strobes are masked for the whole cycle it is held.
    assign decode_strobe = (phase == 4'd1) && !halted && !reset;
    assign commit_strobe = commit_edge && !halted && !reset;

    always_comb begin
        next_pc = pc_plus_one;
        if (stall) begin
            next_pc = readAddress;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    assign pc_fault = (next_pc >= MEM_LIMIT);

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        case (state)
            RUNNING: begin
                // A halt request on the commit edge still retires the slot but suppresses the PC update.
                if (halt_req) begin
                    state_next = STOPPED;
                end else if (commit_edge) begin
                    if (pc_fault) begin
                        state_next = FAULTED;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            STOPPED: state_next = STOPPED;
            FAULTED: state_next = FAULTED;
            default: state_next = STOPPED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUNNING;
            phase       <= 4'd0;
            readAddress <= 32'd0;
            retired     <= 16'd0;
        end else begin
            state <= state_next;
            // The phase keeps counting while halted to stay aligned with the memory's fetch counter.
            phase <= commit_edge ? 4'd0 : phase + 4'd1;
            if (pc_load) begin
                readAddress <= next_pc;
            end
            if (slot_commit) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule
